// File: rtl/cam_capture_pkg.sv
// Shared types and constants for the camera window capture path.
// Holds the capture FSM encoding, default window geometry and the window-size helper.
package cam_capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VS,
        SYNC,
        CAPTURE,
        DONE
    } cap_state_t;

    localparam int DEF_WIN_X0 = 270;
    localparam int DEF_WIN_Y0 = 190;
    localparam int DEF_WIN_W  = 100;
    localparam int DEF_WIN_H  = 100;

    // Number of RAM words one complete window occupies.
    function automatic int win_words(input int w, input int h, input bit decim2);
        return decim2 ? (w / 2) * (h / 2) : w * h;
    endfunction

endpackage

// File: rtl/cam_pixel_tracker.sv
// Purpose: decodes the two-byte camera stream into pixel x/y position and a pixel-complete strobe.
// Latency: x/y are registered; pix_done is combinational on the edge carrying the second byte.
// Backpressure: none, the camera free-runs and every byte must be consumed.
module cam_pixel_tracker #(
    parameter int X_W = 10,
    parameter int Y_W = 9
) (
    input  logic           pclk,
    input  logic           rst_n,
    input  logic           vsync,
    input  logic           href,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           pix_done
);

    logic phase;
    logic href_q;
    logic href_fall;

    assign pix_done  = href & phase;
    assign href_fall = href_q & ~href;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= 1'b0;
            href_q <= 1'b0;
            x      <= '0;
            y      <= '0;
        end else begin
            phase  <= href ? ~phase : 1'b0;
            href_q <= href;

            // Both counters saturate so an oversized frame cannot alias back into the window.
            if (vsync || !href)
                x <= '0;
            else if (pix_done && (x != '1))
                x <= x + X_W'(1);

            if (vsync)
                y <= '0;
            else if (href_fall && (y != '1))
                y <= y + Y_W'(1);
        end
    end

endmodule

// File: rtl/cam_window_capture.sv
// Purpose: writes a rectangular window of the camera frame into RAM under arm/continuous control; CAM_DECIM2_EN adds 2:1 decimation.
// Latency: one pclk from the second pixel byte to wren/data/wraddr.
// Backpressure: none, the RAM write port always accepts; a frame cut short by vsync is retried.
module cam_window_capture
    import cam_capture_pkg::*;
#(
    parameter int DATA_W = 3,
    parameter int X_W    = 10,
    parameter int Y_W    = 9,
    parameter int ADDR_W = 16,
    parameter int WIN_X0 = DEF_WIN_X0,
    parameter int WIN_Y0 = DEF_WIN_Y0,
    parameter int WIN_W  = DEF_WIN_W,
    parameter int WIN_H  = DEF_WIN_H
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [DATA_W-1:0] d,
    input  logic              arm,
    input  logic              mode_cont,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] wraddr,
    output logic              wren,
    output logic              busy,
    output logic              frame_done,
    output logic              short_frame
);

`ifdef CAM_DECIM2_EN
    localparam bit DECIM2 = 1'b1;
`else
    localparam bit DECIM2 = 1'b0;
`endif

    localparam int              WORDS = win_words(WIN_W, WIN_H, DECIM2);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);
    localparam logic [X_W-1:0]  X_LO  = X_W'(WIN_X0);
    localparam logic [X_W-1:0]  X_HI  = X_W'(WIN_X0 + WIN_W - 1);
    localparam logic [Y_W-1:0]  Y_LO  = Y_W'(WIN_Y0);
    localparam logic [Y_W-1:0]  Y_HI  = Y_W'(WIN_Y0 + WIN_H - 1);

    if (longint'(WIN_W) * longint'(WIN_H) > (longint'(1) << ADDR_W)) begin : g_chk_addr
        $error("cam_window_capture: window does not fit in ADDR_W address space");
    end
    if (longint'(WIN_X0) + longint'(WIN_W) > (longint'(1) << X_W)) begin : g_chk_x
        $error("cam_window_capture: window exceeds X_W column range");
    end
    if (longint'(WIN_Y0) + longint'(WIN_H) > (longint'(1) << Y_W)) begin : g_chk_y
        $error("cam_window_capture: window exceeds Y_W line range");
    end
    if (DECIM2 && (((WIN_W % 2) != 0) || ((WIN_H % 2) != 0))) begin : g_chk_decim
        $error("cam_window_capture: decimation needs even window width and height");
    end

    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           pix_done;

    cam_pixel_tracker #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_tracker (
        .pclk     (pclk),
        .rst_n    (rst_n),
        .vsync    (vsync),
        .href     (href),
        .x        (x),
        .y        (y),
        .pix_done (pix_done)
    );

    cap_state_t        state, state_nxt;
    logic [ADDR_W-1:0] count, count_nxt;
    logic              in_win;
    logic              keep;
    logic              wr_hit;
    logic              done_nxt;
    logic              short_nxt;

    assign in_win = (x >= X_LO) && (x <= X_HI) && (y >= Y_LO) && (y <= Y_HI);

`ifdef CAM_DECIM2_EN
    // Even offset from the window origin is just matching LSBs.
    assign keep = ~(x[0] ^ X_LO[0]) & ~(y[0] ^ Y_LO[0]);
`else
    assign keep = 1'b1;
`endif

    assign wr_hit = (state == CAPTURE) && pix_done && in_win && keep;
    assign busy   = (state == WAIT_VS) || (state == SYNC) || (state == CAPTURE);

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        done_nxt  = 1'b0;
        short_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (arm || mode_cont)
                    state_nxt = WAIT_VS;
            end
            WAIT_VS: begin
                if (vsync)
                    state_nxt = SYNC;
            end
            SYNC: begin
                if (!vsync) begin
                    state_nxt = CAPTURE;
                    count_nxt = '0;
                end
            end
            CAPTURE: begin
                // The final write wins over a coincident vsync so a complete window is never discarded.
                if (wr_hit && (count == LAST)) begin
                    state_nxt = DONE;
                end else if (vsync) begin
                    short_nxt = 1'b1;
                    count_nxt = '0;
                    state_nxt = SYNC;
                end else if (wr_hit) begin
                    count_nxt = count + ADDR_W'(1);
                end
            end
            DONE: begin
                done_nxt  = 1'b1;
                state_nxt = mode_cont ? WAIT_VS : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            data        <= '0;
            wraddr      <= '0;
            wren        <= 1'b0;
            frame_done  <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            wren        <= wr_hit;
            frame_done  <= done_nxt;
            short_frame <= short_nxt;
            if (wr_hit) begin
                data   <= d;
                wraddr <= count;
            end
        end
    end

endmodule
